// File: rtl/inventory_pkg.sv
// Shared types and helpers for the consumable-item inventory.
// Holds channel state encoding, saturating count step and defaults.
package inventory_pkg;

    localparam int DEF_NUM_ITEMS       = 2;
    localparam int DEF_CNT_W           = 3;
    localparam int DEF_MAX_COUNT       = 3;
    localparam int DEF_INIT_COUNT      = 3;
    localparam int DEF_COOLDOWN_FRAMES = 30;

    typedef enum logic [1:0] {
        ST_ARMED    = 2'd0,
        ST_HOLD     = 2'd1,
        ST_COOLDOWN = 2'd2
    } chan_state_e;

    // A use and a pickup in the same cycle cancel out.
    function automatic int sat_step(
        input int   cnt,
        input logic inc,
        input logic dec,
        input int   max_cnt
    );
        int res;
        res = cnt;
        if (dec && !inc) begin
            res = cnt - 1;
        end else if (inc && !dec && (cnt < max_cnt)) begin
            res = cnt + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/item_channel.sv
// One inventory channel: use/re-arm FSM, saturating count, cooldown.
// Cooldown state and counter exist only with ITEM_COOLDOWN_EN.
module item_channel
    import inventory_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int MAX_COUNT  = DEF_MAX_COUNT,
    parameter int INIT_COUNT = DEF_INIT_COUNT
`ifdef ITEM_COOLDOWN_EN
    ,
    parameter int COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES
`endif
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             frame_tick,
    input  logic             game_restart,
    input  logic             use_req,
    input  logic             refill,
    input  logic             grant,
    output logic             eligible,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             armed,
    output logic             use_pulse
);

    chan_state_e      state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             empty_q, empty_d;
    logic             pulse_q, pulse_d;

`ifdef ITEM_COOLDOWN_EN
    localparam int CD_W = $clog2(COOLDOWN_FRAMES + 1);
    logic [CD_W-1:0] cd_q, cd_d;
`endif

    assign armed     = (state_q == ST_ARMED);
    assign eligible  = armed && use_req && (count_q != '0);
    assign count     = count_q;
    assign empty     = empty_q;
    assign use_pulse = pulse_q;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        pulse_d = 1'b0;
`ifdef ITEM_COOLDOWN_EN
        cd_d    = cd_q;
`endif
        if (game_restart) begin
            state_d = ST_ARMED;
            count_d = CNT_W'(INIT_COUNT);
`ifdef ITEM_COOLDOWN_EN
            cd_d    = '0;
`endif
        end else begin
            count_d = CNT_W'(sat_step(int'(count_q), refill, grant, MAX_COUNT));
            pulse_d = grant;
            unique case (state_q)
                ST_ARMED: begin
                    if (grant) state_d = ST_HOLD;
                end
                ST_HOLD: begin
                    // Key must be released before a maintenance tick re-arms.
                    if (frame_tick && !use_req) begin
`ifdef ITEM_COOLDOWN_EN
                        state_d = ST_COOLDOWN;
                        cd_d    = '0;
`else
                        state_d = ST_ARMED;
`endif
                    end
                end
`ifdef ITEM_COOLDOWN_EN
                ST_COOLDOWN: begin
                    if (frame_tick) begin
                        cd_d = cd_q + 1'b1;
                        if (cd_d == CD_W'(COOLDOWN_FRAMES)) state_d = ST_ARMED;
                    end
                end
`endif
                default: state_d = ST_ARMED;
            endcase
        end
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= ST_ARMED;
            count_q <= CNT_W'(INIT_COUNT);
            empty_q <= (INIT_COUNT == 0);
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            empty_q <= empty_d;
            pulse_q <= pulse_d;
        end
    end

`ifdef ITEM_COOLDOWN_EN
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) cd_q <= '0;
        else         cd_q <= cd_d;
    end
`endif

endmodule

// File: rtl/item_inventory.sv
// Multi-channel consumable-item counter with fixed-priority use arbiter.
// Optional re-arm cooldown enabled by defining ITEM_COOLDOWN_EN.
module item_inventory
    import inventory_pkg::*;
#(
    parameter int NUM_ITEMS       = DEF_NUM_ITEMS,
    parameter int CNT_W           = DEF_CNT_W,
    parameter int MAX_COUNT       = DEF_MAX_COUNT,
    parameter int INIT_COUNT      = DEF_INIT_COUNT,
    parameter int COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic                       frame_tick,
    input  logic                       game_restart,
    input  logic [NUM_ITEMS-1:0]       use_req,
    input  logic [NUM_ITEMS-1:0]       refill,
    output logic [NUM_ITEMS*CNT_W-1:0] counts,
    output logic [NUM_ITEMS-1:0]       use_pulse,
    output logic [NUM_ITEMS-1:0]       empty,
    output logic [NUM_ITEMS-1:0]       armed
);

`ifdef ITEM_COOLDOWN_EN
    localparam bit CD_BAD = (COOLDOWN_FRAMES < 1);
`else
    localparam bit CD_BAD = (COOLDOWN_FRAMES < 0);
`endif

    localparam bit PARAM_BAD = (NUM_ITEMS < 1) || (NUM_ITEMS > 8) ||
                               (CNT_W < 1) ||
                               (MAX_COUNT >= (1 << CNT_W)) ||
                               (INIT_COUNT < 0) ||
                               (INIT_COUNT > MAX_COUNT) || CD_BAD;

    generate
        if (PARAM_BAD) begin : g_param_check
            $error("item_inventory: parameter out of range");
        end
    endgenerate

    logic [NUM_ITEMS-1:0] eligible;
    logic [NUM_ITEMS-1:0] grant;

    // Lowest eligible index wins; the rest retry next cycle.
    always_comb begin
        logic found;
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (eligible[i] && !found) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_ITEMS; i++) begin : g_chan
        item_channel #(
            .CNT_W          (CNT_W),
            .MAX_COUNT      (MAX_COUNT),
            .INIT_COUNT     (INIT_COUNT)
`ifdef ITEM_COOLDOWN_EN
            ,
            .COOLDOWN_FRAMES(COOLDOWN_FRAMES)
`endif
        ) u_chan (
            .clk         (clk),
            .resetN      (resetN),
            .frame_tick  (frame_tick),
            .game_restart(game_restart),
            .use_req     (use_req[i]),
            .refill      (refill[i]),
            .grant       (grant[i]),
            .eligible    (eligible[i]),
            .count       (counts[i*CNT_W +: CNT_W]),
            .empty       (empty[i]),
            .armed       (armed[i]),
            .use_pulse   (use_pulse[i])
        );
    end

endmodule
